dm_access_unit: RTL and testbench

- Data-memory side of the control path. Consumes the DM_en / DM_write strobes from the decoder, plus the ALU address, store data and funct3.
- Runs a req/ack transaction to the data SRAM port and stalls the pipeline until the transaction completes.
- Returns sign/zero-extended load data to the DM-to-Reg writeback mux.
- Sits between the EX/MEM stage and the data memory.

---
 rtl/riscv_pkg.sv | 39 +++
 rtl/dm_load_align.sv | 29 ++
 rtl/dm_access_unit.sv | 181 ++++++++++++++++++
 tb/tb_dm_access_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 control-path types: load/store funct3 codes, the
// data-memory FSM state type and byte-enable encodings.
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] BE_B0 = 4'b0001;
   localparam logic [3:0] BE_H0 = 4'b0011;
   localparam logic [3:0] BE_H1 = 4'b1100;
   localparam logic [3:0] BE_W  = 4'b1111;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } dm_state_t;

   typedef enum logic [1:0] {
      SZ_B,
      SZ_H,
      SZ_W
   } dm_size_t;

   // Undefined funct3 encodings fall through to a word access.
   function automatic dm_size_t f3_size(input logic [2:0] f3);
      dm_size_t sz;
      case (f3)
         F3_B, F3_BU: sz = SZ_B;
         F3_H, F3_HU: sz = SZ_H;
         default:     sz = SZ_W;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/dm_load_align.sv
// Load lane select and sign/zero extension of the SRAM read word,
// driven by the latched byte offset and funct3.
module dm_load_align
   import riscv_pkg::*;
(
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata
);

   logic [31:0] shifted;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      shifted = mem_rdata >> {off, 3'b000};
      byte_v  = shifted[7:0];
      half_v  = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3)
         F3_B:    rdata = {{24{byte_v[7]}}, byte_v};
         F3_BU:   rdata = {24'h0, byte_v};
         F3_H:    rdata = {{16{half_v[15]}}, half_v};
         F3_HU:   rdata = {16'h0, half_v};
         default: rdata = mem_rdata;
      endcase
   end

endmodule

// File: rtl/dm_access_unit.sv
// Data-memory access FSM: req/ack to the SRAM, pipeline stall and
// extended load return. Define DM_ACCESS_TIMEOUT_EN for the ack timeout.
module dm_access_unit
   import riscv_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              dm_en,
   input  logic              dm_write,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              stall,
   output logic [DATA_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   dm_state_t         state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rdata_valid_q, rdata_valid_d;
   logic              err_q, err_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        off_q, off_d;

`ifdef DM_ACCESS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT);
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   dm_size_t          size_in;
   logic              aligned;
   logic [DATA_W-1:0] ld_data;

   dm_load_align u_align (
      .mem_rdata (mem_rdata),
      .off       (off_q),
      .funct3    (funct3_q),
      .rdata     (ld_data)
   );

   always_comb begin
      size_in = f3_size(funct3);
      case (size_in)
         SZ_B:    aligned = 1'b1;
         SZ_H:    aligned = ~addr[0];
         default: aligned = (addr[1:0] == 2'b00);
      endcase
   end

   assign stall = (state_q == IDLE && dm_en && aligned) || (state_q == REQ);

   always_comb begin
      state_d       = state_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_be_d      = mem_be_q;
      rdata_d       = rdata_q;
      rdata_valid_d = 1'b0;
      err_d         = 1'b0;
      funct3_d      = funct3_q;
      off_d         = off_q;
`ifdef DM_ACCESS_TIMEOUT_EN
      cnt_d         = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (dm_en && aligned) begin
               state_d    = REQ;
               mem_req_d  = 1'b1;
               mem_we_d   = dm_write;
               mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
               funct3_d   = funct3;
               off_d      = addr[1:0];
               case (size_in)
                  SZ_B: begin
                     mem_be_d    = BE_B0 << addr[1:0];
                     mem_wdata_d = {4{wdata[7:0]}};
                  end
                  SZ_H: begin
                     mem_be_d    = addr[1] ? BE_H1 : BE_H0;
                     mem_wdata_d = {2{wdata[15:0]}};
                  end
                  default: begin
                     mem_be_d    = BE_W;
                     mem_wdata_d = wdata;
                  end
               endcase
               if (!dm_write) mem_be_d = BE_W;
            end else if (dm_en) begin
               err_d = 1'b1;
            end
         end
         REQ: begin
            if (mem_ack) begin
               state_d   = DONE;
               mem_req_d = 1'b0;
`ifdef DM_ACCESS_TIMEOUT_EN
               cnt_d     = '0;
`endif
               if (!mem_we_q) begin
                  rdata_d       = ld_data;
                  rdata_valid_d = 1'b1;
               end
`ifdef DM_ACCESS_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d   = DONE;
               mem_req_d = 1'b0;
               err_d     = 1'b1;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_be_q      <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         err_q         <= 1'b0;
         funct3_q      <= '0;
         off_q         <= '0;
`ifdef DM_ACCESS_TIMEOUT_EN
         cnt_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_be_q      <= mem_be_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         err_q         <= err_d;
         funct3_q      <= funct3_d;
         off_q         <= off_d;
`ifdef DM_ACCESS_TIMEOUT_EN
         cnt_q         <= cnt_d;
`endif
      end
   end

   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_be      = mem_be_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rdata_valid_q;
   assign err         = err_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit; checks loads, stores, misalignment,
// reset during a request and the ack-wait behaviour of either build.
module tb_dm_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        dm_en;
   logic        dm_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] rdata;
   logic        rdata_valid;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   dm_access_unit #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .dm_en       (dm_en),
      .dm_write    (dm_write),
      .funct3      (funct3),
      .addr        (addr),
      .wdata       (wdata),
      .stall       (stall),
      .rdata       (rdata),
      .rdata_valid (rdata_valid),
      .err         (err),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_be      (mem_be),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One aligned access; ack arrives in REQ cycle number wait_n+1.
   task automatic xact(input string tag, input logic w,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int wait_n,
                       input logic [31:0] mrd, input logic [31:0] exp_rd,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd);
      int stalls;
      @(negedge clk);
      dm_en = 1'b1; dm_write = w; funct3 = f3; addr = a; wdata = wd;
      #1;
      chk({tag, ".stall0"}, {31'd0, stall}, 32'd1);
      stalls = 1;
      @(negedge clk);
      dm_en = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0;
      #1;
      chk({tag, ".req"}, {31'd0, mem_req}, 32'd1);
      chk({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
      chk({tag, ".be"}, {28'd0, mem_be}, {28'd0, exp_be});
      chk({tag, ".we"}, {31'd0, mem_we}, {31'd0, w});
      if (w) chk({tag, ".wdata"}, mem_wdata, exp_wd);
      if (stall) stalls++;
      for (int i = 0; i < wait_n; i++) begin
         @(negedge clk);
         #1;
         if (stall) stalls++;
      end
      mem_ack = 1'b1; mem_rdata = mrd;
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'h0;
      #1;
      chk({tag, ".stalls"}, stalls, wait_n + 2);
      chk({tag, ".done_stall"}, {31'd0, stall}, 32'd0);
      chk({tag, ".done_req"}, {31'd0, mem_req}, 32'd0);
      chk({tag, ".rvalid"}, {31'd0, rdata_valid}, {31'd0, ~w});
      if (!w) chk({tag, ".rdata"}, rdata, exp_rd);
      @(negedge clk);
      #1;
      chk({tag, ".rvalid_end"}, {31'd0, rdata_valid}, 32'd0);
   endtask

   initial begin
      int cnt;
      rst = 1'b1; dm_en = 1'b0; dm_write = 1'b0; funct3 = 3'b010;
      addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst.req", {31'd0, mem_req}, 32'd0);
      chk("rst.be", {28'd0, mem_be}, 32'd0);
      chk("rst.addr", mem_addr, 32'd0);
      chk("rst.rdata", rdata, 32'd0);
      chk("rst.err", {31'd0, err}, 32'd0);
      chk("rst.stall", {31'd0, stall}, 32'd0);
      rst = 1'b0;

      xact("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 1,
           32'hDEADBEEF, 32'hDEADBEEF, 4'b1111, 32'h0);
      xact("sb103", 1'b1, 3'b000, 32'h103, 32'h000000A5, 0,
           32'h0, 32'h0, 4'b1000, 32'hA5A5A5A5);
      xact("sh102", 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 0,
           32'h0, 32'h0, 4'b1100, 32'hBEEFBEEF);
      xact("sb101", 1'b1, 3'b000, 32'h101, 32'h0000003C, 2,
           32'h0, 32'h0, 4'b0010, 32'h3C3C3C3C);
      xact("sw108", 1'b1, 3'b010, 32'h108, 32'hCAFEF00D, 0,
           32'h0, 32'h0, 4'b1111, 32'hCAFEF00D);
      xact("lb102", 1'b0, 3'b000, 32'h102, 32'h0, 0,
           32'h00800000, 32'hFFFFFF80, 4'b1111, 32'h0);
      xact("lbu102", 1'b0, 3'b100, 32'h102, 32'h0, 0,
           32'h00800000, 32'h00000080, 4'b1111, 32'h0);
      xact("lh102", 1'b0, 3'b001, 32'h102, 32'h0, 0,
           32'h80010000, 32'hFFFF8001, 4'b1111, 32'h0);
      xact("lhu100", 1'b0, 3'b101, 32'h100, 32'h0, 0,
           32'hFFFF8001, 32'h00008001, 4'b1111, 32'h0);
      xact("lb101", 1'b0, 3'b000, 32'h101, 32'h0, 0,
           32'h11227F44, 32'h0000007F, 4'b1111, 32'h0);
      xact("f3_011", 1'b0, 3'b011, 32'h104, 32'h0, 0,
           32'h12345678, 32'h12345678, 4'b1111, 32'h0);

      // Misaligned word: err pulse, no request, no stall.
      @(negedge clk);
      dm_en = 1'b1; dm_write = 1'b0; funct3 = 3'b010; addr = 32'h102;
      #1;
      chk("mis_w.stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      dm_en = 1'b0;
      #1;
      chk("mis_w.err", {31'd0, err}, 32'd1);
      chk("mis_w.req", {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      #1;
      chk("mis_w.err_end", {31'd0, err}, 32'd0);
      chk("mis_w.req_end", {31'd0, mem_req}, 32'd0);

      // Misaligned halfword store.
      @(negedge clk);
      dm_en = 1'b1; dm_write = 1'b1; funct3 = 3'b001; addr = 32'h101;
      #1;
      chk("mis_h.stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      dm_en = 1'b0;
      #1;
      chk("mis_h.err", {31'd0, err}, 32'd1);
      chk("mis_h.req", {31'd0, mem_req}, 32'd0);

      // Stray ack in IDLE is ignored.
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'h55555555;
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      chk("stray.rvalid", {31'd0, rdata_valid}, 32'd0);
      chk("stray.req", {31'd0, mem_req}, 32'd0);

      // Reset while a load is outstanding.
      @(negedge clk);
      dm_en = 1'b1; dm_write = 1'b0; funct3 = 3'b010; addr = 32'h200;
      @(negedge clk);
      dm_en = 1'b0;
      #1;
      chk("rstreq.req", {31'd0, mem_req}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h99999999;
      #1;
      chk("rstreq.req0", {31'd0, mem_req}, 32'd0);
      chk("rstreq.stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      chk("rstreq.rvalid", {31'd0, rdata_valid}, 32'd0);
      chk("rstreq.req1", {31'd0, mem_req}, 32'd0);
      chk("rstreq.rdata", rdata, 32'd0);

      // Withheld ack.
      @(negedge clk);
      dm_en = 1'b1; dm_write = 1'b0; funct3 = 3'b010; addr = 32'h300;
      @(negedge clk);
      dm_en = 1'b0;
`ifdef DM_ACCESS_TIMEOUT_EN
      cnt = 0;
      #1;
      while (mem_req && cnt < 40) begin
         cnt++;
         @(negedge clk);
         #1;
      end
      chk("tmo.req_cycles", cnt, 32'd16);
      chk("tmo.err", {31'd0, err}, 32'd1);
      chk("tmo.rvalid", {31'd0, rdata_valid}, 32'd0);
      chk("tmo.stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      #1;
      chk("tmo.err_end", {31'd0, err}, 32'd0);
      chk("tmo.idle_req", {31'd0, mem_req}, 32'd0);
`else
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (mem_req && stall && !err) cnt++;
      end
      chk("wait.req_cycles", cnt, 32'd20);
      mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      chk("wait.rvalid", {31'd0, rdata_valid}, 32'd1);
      chk("wait.rdata", rdata, 32'h0BADF00D);
      chk("wait.err", {31'd0, err}, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
